// File: rtl/iris_sample_loader.sv
// iris_sample_loader: frames a byte stream into 4-feature samples and runs one classifier inference per sample
module iris_sample_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  En,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] X1,
  output logic [DATA_WIDTH-1:0] X2,
  output logic [DATA_WIDTH-1:0] X3,
  output logic [DATA_WIDTH-1:0] X4,
  output logic                  Run,
  input  logic                  nn_done,
  input  logic [2:0]            nn_class,
  output logic [2:0]            class_out,
  output logic                  class_valid,
  output logic                  frame_err,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  sample_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {LOAD, BUSY, REPORT} state_t;
  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] x_q [4];
  logic [DATA_WIDTH-1:0] x_d [4];
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]            class_q, class_d;
  logic                  run_q, run_d, ready_q, ready_d;
  logic                  cv_q, cv_d, fe_q, fe_d, te_q, te_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    class_d = class_q;
    run_d   = run_q;
    ready_d = 1'b0;
    cv_d    = 1'b0;
    fe_d    = 1'b0;
    te_d    = 1'b0;
    if (En) begin
      case (state_q)
        LOAD: if (s_valid && ready_q) begin
          x_d[idx_q] = s_data;
          idx_d = idx_q + 2'd1;
          if (s_last != (idx_q == 2'd3)) begin
            fe_d  = 1'b1;
            idx_d = 2'd0;
          end else if (s_last) begin
            state_d = BUSY;
            run_d   = 1'b1;
          end
        end
        BUSY: begin
          tmo_d = tmo_q + TW'(1);
          // a zero counter marks the first BUSY cycle, where a stale done level is ignored
          if (nn_done && tmo_q != '0) begin
            state_d = REPORT;
            class_d = nn_class;
            run_d   = 1'b0;
            tmo_d   = '0;
            cv_d    = 1'b1;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = LOAD;
            run_d   = 1'b0;
            tmo_d   = '0;
            te_d    = 1'b1;
          end
        end
        default: state_d = LOAD;
      endcase
      ready_d = state_d == LOAD;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      x_q     <= '{default: '0};
      tmo_q   <= '0;
      cnt_q   <= '0;
      class_q <= '0;
      run_q   <= 1'b0;
      ready_q <= 1'b0;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
      run_q   <= run_d;
      ready_q <= ready_d;
      cv_q    <= cv_d;
      fe_q    <= fe_d;
      te_q    <= te_d;
    end
  end
  assign s_ready     = ready_q;
  assign X1          = x_q[0];
  assign X2          = x_q[1];
  assign X3          = x_q[2];
  assign X4          = x_q[3];
  assign Run         = run_q;
  assign class_out   = class_q;
  assign class_valid = cv_q;
  assign frame_err   = fe_q;
  assign timeout_err = te_q;
  assign sample_cnt  = cnt_q;
endmodule

// File: tb/tb_iris_sample_loader.sv
// tb_iris_sample_loader: randomized scenario bench for iris_sample_loader against a sample-level reference model
module tb_iris_sample_loader;
  localparam int T = 8;
  logic clk = 0, rst = 0, En = 0, s_valid = 0, s_last = 0, nn_done = 0;
  logic [7:0] s_data = 0;
  logic [2:0] nn_class = 0;
  logic s_ready, Run, class_valid, frame_err, timeout_err;
  logic [7:0] X1, X2, X3, X4;
  logic [2:0] class_out;
  logic [1:0] sample_cnt;
  int checks = 0, passed = 0;
  int m_cnt = 0;
  logic [2:0] m_cls = 0;

  iris_sample_loader #(.DATA_WIDTH(8), .TIMEOUT_CYC(T), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .En(En), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .Run(Run), .nn_done(nn_done),
    .nn_class(nn_class), .class_out(class_out), .class_valid(class_valid), .frame_err(frame_err),
    .timeout_err(timeout_err), .sample_cnt(sample_cnt));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: done counts from max(d,2); anything beyond T cycles in BUSY aborts
  function automatic int exp_runs(input int d);
    int e = (d < 2) ? 2 : d;
    return (e > T) ? T : e;
  endfunction

  function automatic bit exp_ok(input int d);
    return ((d < 2) ? 2 : d) <= T;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    s_valid = 1; s_data = d; s_last = l;
    while (!(s_ready === 1'b1 && En) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      $display("FAIL send_byte: s_ready=%b never became 1", s_ready);
    end
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_frame(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], i == 3);
  endtask

  task automatic busy_phase(input int d, input int p, output int runs, output logic cv,
                            output logic te, output logic [2:0] co, output logic [1:0] sc);
    int k = 1, frz = 0;
    runs = 0;
    while (Run === 1'b1 && runs < 60) begin
      runs++;
      if (k == p && frz < 3) begin En = 0; nn_done = 1; frz++; end
      else begin En = 1; nn_done = (k >= d); k++; end
      @(negedge clk);
    end
    cv = class_valid; te = timeout_err; co = class_out; sc = sample_cnt;
    En = 1; nn_done = 0;
  endtask

  task automatic reset_dut;
    rst = 0; En = 1; s_valid = 0; nn_done = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    m_cnt = 0; m_cls = 0;
  endtask

  task automatic test_reset;
    rst = 0; En = 1;
    @(negedge clk);
    checks++;
    if ({Run, s_ready, class_valid, frame_err, timeout_err, class_out, sample_cnt, X1, X2, X3, X4} !== '0)
      $display("FAIL reset_values: outputs=%h want 0",
               {Run, s_ready, class_valid, frame_err, timeout_err, class_out, sample_cnt, X1, X2, X3, X4});
    else passed++;
    rst = 1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || Run !== 1'b0) $display("FAIL reset_release: s_ready=%b Run=%b want 1 0", s_ready, Run);
    else passed++;
    m_cnt = 0; m_cls = 0;
  endtask

  task automatic test_basic;
    int runs; logic cv, te; logic [2:0] co; logic [1:0] sc;
    nn_class = 3'b010;
    send_frame({8'd40, 8'd30, 8'd20, 8'd10});
    checks++;
    if ({X4, X3, X2, X1} !== {8'd40, 8'd30, 8'd20, 8'd10}) $display("FAIL basic_x: got %h want 281e140a", {X4, X3, X2, X1});
    else passed++;
    busy_phase(5, 0, runs, cv, te, co, sc);
    checks++;
    if (runs !== 5) $display("FAIL basic_run_len: got %0d want 5", runs); else passed++;
    checks++;
    if ({cv, te, co, sc, s_ready} !== {1'b1, 1'b0, 3'd2, 2'd1, 1'b0})
      $display("FAIL basic_report: cv=%b te=%b class=%0d cnt=%0d rdy=%b want 1 0 2 1 0", cv, te, co, sc, s_ready);
    else passed++;
    @(negedge clk);
    checks++;
    if (class_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL basic_after: cv=%b rdy=%b want 0 1", class_valid, s_ready);
    else passed++;
    m_cnt = 1; m_cls = 3'd2;
  endtask

  task automatic test_frame_err;
    logic [31:0] w; int runs, d; logic cv, te; logic [2:0] co, cls; logic [1:0] sc;
    send_byte(8'd5, 0);
    send_byte(8'd6, 1);
    checks++;
    if ({frame_err, Run, X2, X1} !== {1'b1, 1'b0, 8'd6, 8'd5})
      $display("FAIL early_last: fe=%b Run=%b X2=%0d X1=%0d want 1 0 6 5", frame_err, Run, X2, X1);
    else passed++;
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) $display("FAIL fe_pulse_len: got %b want 0", frame_err); else passed++;
    w = $urandom;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
    checks++;
    if ({frame_err, Run, X4, X3, X2, X1} !== {1'b1, 1'b0, w})
      $display("FAIL missing_last: fe=%b Run=%b X=%h want 1 0 %h", frame_err, Run, {X4, X3, X2, X1}, w);
    else passed++;
    w = $urandom; d = $urandom_range(2, T); cls = 3'($urandom);
    nn_class = cls;
    send_frame(w);
    checks++;
    if ({X4, X3, X2, X1} !== w) $display("FAIL fe_recover_x: got %h want %h", {X4, X3, X2, X1}, w); else passed++;
    busy_phase(d, 0, runs, cv, te, co, sc);
    m_cnt++; m_cls = cls;
    checks++;
    if ({runs, cv, co, sc} !== {exp_runs(d), 1'b1, m_cls, 2'(m_cnt)})
      $display("FAIL fe_recover: runs=%0d cv=%b class=%0d cnt=%0d want %0d 1 %0d %0d", runs, cv, co, sc, exp_runs(d), m_cls, 2'(m_cnt));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_guard_timeout;
    int runs; logic cv, te; logic [2:0] co; logic [1:0] sc;
    nn_class = 3'd5; nn_done = 1;
    send_frame($urandom);
    busy_phase(0, 0, runs, cv, te, co, sc);
    m_cnt++; m_cls = 3'd5;
    checks++;
    if ({runs, cv, te, co, sc} !== {32'd2, 1'b1, 1'b0, 3'd5, 2'(m_cnt)})
      $display("FAIL done_guard: runs=%0d cv=%b te=%b class=%0d cnt=%0d want 2 1 0 5 %0d", runs, cv, te, co, sc, 2'(m_cnt));
    else passed++;
    @(negedge clk);
    nn_class = 3'd7;
    send_frame($urandom);
    busy_phase(1000, 0, runs, cv, te, co, sc);
    checks++;
    if ({runs, cv, te, co, sc, s_ready} !== {T, 1'b0, 1'b1, m_cls, 2'(m_cnt), 1'b1})
      $display("FAIL timeout: runs=%0d cv=%b te=%b class=%0d cnt=%0d rdy=%b want %0d 0 1 %0d %0d 1",
               runs, cv, te, co, sc, s_ready, T, m_cls, 2'(m_cnt));
    else passed++;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL te_pulse_len: got %b want 0", timeout_err); else passed++;
  endtask

  task automatic test_enable_freeze;
    logic [31:0] w; logic [7:0] old3; int runs, bad = 0; logic cv, te; logic [2:0] co; logic [1:0] sc;
    w = $urandom; old3 = X3; nn_class = 3'd4;
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    En = 0; s_valid = 1; s_data = w[23:16] ^ 8'hff; s_last = 1;
    repeat (3) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || X3 !== old3 || Run !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL load_freeze: %0d cycles moved, rdy=%b X3=%0d want 0 %0d", bad, s_ready, X3, old3);
    else passed++;
    s_valid = 0; En = 1;
    send_byte(w[23:16], 0);
    send_byte(w[31:24], 1);
    checks++;
    if ({X4, X3, X2, X1} !== w) $display("FAIL freeze_x: got %h want %h", {X4, X3, X2, X1}, w); else passed++;
    busy_phase(T, 3, runs, cv, te, co, sc);
    m_cnt++; m_cls = 3'd4;
    checks++;
    if ({runs, cv, te, co, sc} !== {T + 3, 1'b1, 1'b0, 3'd4, 2'(m_cnt)})
      $display("FAIL busy_freeze: runs=%0d cv=%b te=%b class=%0d cnt=%0d want %0d 1 0 4 %0d", runs, cv, te, co, sc, T + 3, 2'(m_cnt));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [31:0] w; int runs, d; logic cv, te; logic [2:0] co; logic [1:0] sc;
    nn_class = 3'd6;
    send_frame($urandom);
    @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({Run, s_ready, class_valid, frame_err, timeout_err, class_out, sample_cnt, X1, X2, X3, X4} !== '0)
      $display("FAIL async_reset: Run=%b outputs=%h want 0", Run,
               {s_ready, class_valid, frame_err, timeout_err, class_out, sample_cnt, X1, X2, X3, X4});
    else passed++;
    @(negedge clk);
    rst = 1; m_cnt = 0; m_cls = 0;
    @(negedge clk);
    w = $urandom; d = $urandom_range(2, T); nn_class = 3'd3;
    send_frame(w);
    busy_phase(d, 0, runs, cv, te, co, sc);
    checks++;
    if ({runs, cv, co, sc} !== {exp_runs(d), 1'b1, 3'd3, 2'd1})
      $display("FAIL post_reset: runs=%0d cv=%b class=%0d cnt=%0d want %0d 1 3 1", runs, cv, co, sc, exp_runs(d));
    else passed++;
    m_cnt = 1; m_cls = 3'd3;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap;
    int runs, d, bad = 0; logic cv, te; logic [2:0] co, cls; logic [1:0] sc;
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_dut;
    for (int i = 0; i < 5; i++) begin
      d = $urandom_range(2, T); cls = 3'($urandom); nn_class = cls;
      send_frame($urandom);
      busy_phase(d, 0, runs, cv, te, co, sc);
      checks++;
      if (sc !== want[i] || co !== cls || cv !== 1'b1) begin
        bad++;
        $display("FAIL cnt_wrap[%0d]: cnt=%0d class=%0d cv=%b want %0d %0d 1", i, sc, co, cv, want[i], cls);
      end else passed++;
      @(negedge clk);
    end
    m_cnt = 5; m_cls = nn_class;
  endtask

  task automatic test_back_to_back;
    logic [31:0] w; int runs, d; logic cv, te; logic [2:0] co, cls; logic [1:0] sc; bit ok;
    for (int i = 0; i < 10; i++) begin
      w = $urandom; d = $urandom_range(0, T + 3); cls = 3'($urandom);
      nn_class = cls; nn_done = (d == 0);
      send_frame(w);
      checks++;
      if ({X4, X3, X2, X1} !== w) $display("FAIL b2b_x[%0d]: got %h want %h", i, {X4, X3, X2, X1}, w); else passed++;
      busy_phase(d, 0, runs, cv, te, co, sc);
      ok = exp_ok(d);
      if (ok) begin m_cnt++; m_cls = cls; end
      checks++;
      if ({runs, cv, te, co, sc} !== {exp_runs(d), ok, !ok, m_cls, 2'(m_cnt)})
        $display("FAIL b2b[%0d] d=%0d: runs=%0d cv=%b te=%b class=%0d cnt=%0d want %0d %b %b %0d %0d",
                 i, d, runs, cv, te, co, sc, exp_runs(d), ok, !ok, m_cls, 2'(m_cnt));
      else passed++;
      if (ok) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_frame_err;
    test_guard_timeout;
    test_enable_freeze;
    test_async_reset;
    test_counter_wrap;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
